sp_ram_fifo_ctrl: RTL



---
 rtl/sp_ram_fifo_ctrl_pkg.sv | 22 ++
 rtl/sp_fifo_ptr.sv | 27 ++
 rtl/sp_ram_fifo_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/sp_ram_fifo_ctrl_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller: default sizes,
// the per-cycle RAM access kind, and the wrap-around pointer step.
package sp_ram_fifo_ctrl_pkg;

  localparam int          DW_DEF    = 4;
  localparam int          AW_DEF    = 7;
  localparam int unsigned DEPTH_DEF = 128;
  localparam int          CW_DEF    = 8;

  // The single RAM port does at most one of these per cycle.
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } ram_acc_e;

  // Next pointer value, wrapping depth-1 -> 0 so DEPTH need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sp_fifo_ptr.sv
// Wrap-around RAM pointer with synchronous active-low reset, synchronous clear
// and increment enable. Reset and clear both return the pointer to 0.
module sp_fifo_ptr
  import sp_ram_fifo_ctrl_pkg::*;
#(
  parameter int          AW    = AW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // Pointer register: clear beats increment so a flush always lands on 0.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= AW'(ptr_next(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM. Each cycle the RAM port does
// one read (refilling the output register) or one write (accepting an input
// word); reads win. The RAM itself lives beside this block, one level up.
module sp_ram_fifo_ctrl
  import sp_ram_fifo_ctrl_pkg::*;
#(
  parameter int          DW    = DW_DEF,
  parameter int          AW    = AW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int          CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_w_data,
  input  logic [DW-1:0] ram_r_data
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] ram_cnt;
  logic          read_req;
  logic          wr_go;
  ram_acc_e      acc;

  // Refill the output register whenever it is empty or being drained this cycle.
  assign read_req = (ram_cnt != '0) && (!out_valid || out_ready);
  // Writes only get the port when no read is pending and the block is not being cleared.
  assign in_ready = (ram_cnt < CW'(DEPTH)) && !read_req && rst && !flush;
  assign wr_go    = in_valid && in_ready;

  // Classify this cycle's RAM access; reset/flush suppress any state change.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    acc = ACC_IDLE;
    if (rst && !flush) begin
      if (read_req)   acc = ACC_READ;
      else if (wr_go) acc = ACC_WRITE;
    end
  end

  assign ram_enb    = wr_go;
  assign ram_addr   = wr_go ? wr_ptr : rd_ptr;
  assign ram_w_data = in_data;

  sp_fifo_ptr #(.AW(AW), .DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (acc == ACC_WRITE),
    .ptr (wr_ptr)
  );

  sp_fifo_ptr #(.AW(AW), .DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (acc == ACC_READ),
    .ptr (rd_ptr)
  );

  // RAM occupancy: +1 per write, -1 per read; never both in one cycle.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      ram_cnt <= '0;
    end else begin
      unique case (acc)
        ACC_READ:  ram_cnt <= ram_cnt - CW'(1);
        ACC_WRITE: ram_cnt <= ram_cnt + CW'(1);
        default:   ram_cnt <= ram_cnt;
      endcase
    end
  end

  // Output register: capture the combinational RAM read, or drop valid once consumed.
  always_ff @(posedge clk) begin
    // NOTE: only the control state is cleared here; RAM contents are left as-is
    // because pointers and counts already mark every stale word as unused.
    if (!rst || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (acc == ACC_READ) begin
      out_valid <= 1'b1;
      out_data  <= ram_r_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign count = ram_cnt + CW'(out_valid);
  assign full  = (ram_cnt == CW'(DEPTH));
  assign empty = (count == '0);

endmodule
